// File: rtl/dw_cmp_dx_peak.sv
// dw_cmp_dx_peak: windowed peak tracker for the duplex comparator path.
// Accepts a valid/ready stream of samples. For each window of win_len samples
// (0 counts as 1) it reports the max, the min and the index of the first max.
// In simplex mode the whole sample is one operand. In duplex mode two lanes are
// tracked independently: lane 1 is din[p1_width-1:0] and lane 2 is
// din[width-1:p1_width]. tc selects signed (two's complement) or unsigned compare.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    sample handshake; din is the sample
//   tc, dplx, win_len    window config, latched on the first sample of a window
//   out_valid/out_ready  result handshake
//   max_o, min_o         window max/min; in duplex the lanes sit at din's positions
//   max_idx1             index of the first lane-1 max (duplex only, else 0)
//   max_idx2             index of the first lane-2 max (duplex) or full-width max
//   dplx_o, tc_o         config that was used for this result
//
// state | meaning
// IDLE  | waiting for the first sample of a window
// ACC   | accumulating the remaining samples of the window
// HOLD  | result valid, waiting for out_ready
module dw_cmp_dx_peak #(
  parameter int width     = 8,
  parameter int p1_width  = 4,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     din,
  input  logic                 tc,
  input  logic                 dplx,
  input  logic [cnt_width-1:0] win_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     max_o,
  output logic [width-1:0]     min_o,
  output logic [cnt_width-1:0] max_idx1,
  output logic [cnt_width-1:0] max_idx2,
  output logic                 dplx_o,
  output logic                 tc_o
);

  localparam int w2 = width - p1_width;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t               state, state_nxt;
  logic [cnt_width-1:0] cnt, cnt_inc, len_r, len_in;
  logic                 first_ld, acc_upd;

  // Signed compare is done as an unsigned compare after flipping each
  // operand's sign bit. tc_o holds the tc latched for the current window.
  logic [width-1:0]    din_k, max_k, min_k;
  logic [p1_width-1:0] din1_k, max1_k, min1_k;
  logic [w2-1:0]       din2_k, max2_k, min2_k;
  logic                gt_full, lt_full, gt1, lt1, gt2, lt2;

  always_comb begin
    din_k  = din;
    max_k  = max_o;
    min_k  = min_o;
    din_k[width-1] = din[width-1] ^ tc_o;
    max_k[width-1] = max_o[width-1] ^ tc_o;
    min_k[width-1] = min_o[width-1] ^ tc_o;

    din1_k = din[p1_width-1:0];
    max1_k = max_o[p1_width-1:0];
    min1_k = min_o[p1_width-1:0];
    din1_k[p1_width-1] = din[p1_width-1] ^ tc_o;
    max1_k[p1_width-1] = max_o[p1_width-1] ^ tc_o;
    min1_k[p1_width-1] = min_o[p1_width-1] ^ tc_o;

    din2_k = din[width-1:p1_width];
    max2_k = max_o[width-1:p1_width];
    min2_k = min_o[width-1:p1_width];
    din2_k[w2-1] = din[width-1] ^ tc_o;
    max2_k[w2-1] = max_o[width-1] ^ tc_o;
    min2_k[w2-1] = min_o[width-1] ^ tc_o;
  end

  assign gt_full = din_k > max_k;
  assign lt_full = din_k < min_k;
  assign gt1     = din1_k > max1_k;
  assign lt1     = din1_k < min1_k;
  assign gt2     = din2_k > max2_k;
  assign lt2     = din2_k < min2_k;

  assign cnt_inc = cnt + 1'b1;
  assign len_in  = (win_len == '0) ? cnt_width'(1) : win_len;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // in_ready depends only on state and rst, never on out_ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    first_ld  = 1'b0;
    acc_upd   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          first_ld  = 1'b1;
          state_nxt = (len_in == cnt_width'(1)) ? HOLD : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_upd = 1'b1;
          if (cnt_inc == len_r) state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      first_ld  = 1'b0;
      acc_upd   = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_o    <= '0;
      min_o    <= '0;
      max_idx1 <= '0;
      max_idx2 <= '0;
      dplx_o   <= 1'b0;
      tc_o     <= 1'b0;
      cnt      <= '0;
      len_r    <= '0;
    end else if (first_ld) begin
      max_o    <= din;
      min_o    <= din;
      max_idx1 <= '0;
      max_idx2 <= '0;
      dplx_o   <= dplx;
      tc_o     <= tc;
      cnt      <= cnt_width'(1);
      len_r    <= len_in;
    end else if (acc_upd) begin
      cnt <= cnt_inc;
      if (dplx_o) begin
        // Strict compares keep the first occurrence on ties.
        if (gt1) begin
          max_o[p1_width-1:0] <= din[p1_width-1:0];
          max_idx1            <= cnt;
        end
        if (lt1) min_o[p1_width-1:0] <= din[p1_width-1:0];
        if (gt2) begin
          max_o[width-1:p1_width] <= din[width-1:p1_width];
          max_idx2                <= cnt;
        end
        if (lt2) min_o[width-1:p1_width] <= din[width-1:p1_width];
      end else begin
        if (gt_full) begin
          max_o    <= din;
          max_idx2 <= cnt;
        end
        if (lt_full) min_o <= din;
      end
    end
  end

endmodule

// File: tb/tb_dw_cmp_dx_peak.sv
// Testbench for dw_cmp_dx_peak: directed windows checked against a
// queue-based window model on every cycle, plus literal expected results.
module tb_dw_cmp_dx_peak;

  localparam int W  = 8;
  localparam int P1 = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  din = '0;
  logic          tc = 1'b0;
  logic          dplx = 1'b0;
  logic [CW-1:0] win_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  max_o, min_o;
  logic [CW-1:0] max_idx1, max_idx2;
  logic          dplx_o, tc_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  dw_cmp_dx_peak #(.width(W), .p1_width(P1), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .tc(tc), .dplx(dplx), .win_len(win_len), .out_valid(out_valid),
    .out_ready(out_ready), .max_o(max_o), .min_o(min_o), .max_idx1(max_idx1),
    .max_idx2(max_idx2), .dplx_o(dplx_o), .tc_o(tc_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- window model ----------------
  typedef struct {int mx; int mn; int i1; int i2; bit d; bit t;} res_t;
  res_t exp_q[$];
  int   win_q[$];
  bit   m_tc, m_dplx;
  int   m_len;
  bit   prev_rst = 1'b0;
  bit   busy;

  function automatic int sval(input int x, input int w, input bit t);
    if (t && x[w-1]) return x - (1 << w);
    return x;
  endfunction

  function automatic void lane(input int sh, input int w, input bit t,
                               output int mx, output int mn, output int ix);
    int v;
    v  = (win_q[0] >> sh) & ((1 << w) - 1);
    mx = v; mn = v; ix = 0;
    for (int i = 1; i < win_q.size(); i++) begin
      v = (win_q[i] >> sh) & ((1 << w) - 1);
      if (sval(v, w, t) > sval(mx, w, t)) begin mx = v; ix = i; end
      if (sval(v, w, t) < sval(mn, w, t)) mn = v;
    end
  endfunction

  function automatic res_t model_result();
    res_t r;
    int a, b, c, d, e, f;
    if (m_dplx) begin
      lane(0, P1, m_tc, a, b, c);
      lane(P1, W - P1, m_tc, d, e, f);
      r.mx = (d << P1) | a; r.mn = (e << P1) | b; r.i1 = c; r.i2 = f;
    end else begin
      lane(0, W, m_tc, a, b, c);
      r.mx = a; r.mn = b; r.i1 = 0; r.i2 = c;
    end
    r.d = m_dplx; r.t = m_tc;
    return r;
  endfunction

  // Inputs change just after posedge, so values at negedge are what the
  // next posedge samples.
  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_max_o", max_o, 0);
      chk("rst_min_o", min_o, 0);
      chk("rst_idx1", max_idx1, 0);
      chk("rst_idx2", max_idx2, 0);
      chk("rst_cfg_o", {dplx_o, tc_o}, 0);
    end
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      win_q.delete();
      exp_q.delete();
    end else begin
      busy = exp_q.size() > 0;
      chk("out_valid", out_valid, busy);
      chk("in_ready", in_ready, !busy);
      if (busy) begin
        chk("m_max_o", max_o, exp_q[0].mx);
        chk("m_min_o", min_o, exp_q[0].mn);
        chk("m_idx1", max_idx1, exp_q[0].i1);
        chk("m_idx2", max_idx2, exp_q[0].i2);
        chk("m_dplx_o", dplx_o, exp_q[0].d);
        chk("m_tc_o", tc_o, exp_q[0].t);
        if (out_ready) void'(exp_q.pop_front());
      end else if (in_valid) begin
        if (win_q.size() == 0) begin
          m_tc = tc; m_dplx = dplx;
          m_len = (win_len == 0) ? 1 : int'(win_len);
        end
        win_q.push_back(int'(din));
        if (win_q.size() == m_len) begin
          exp_q.push_back(model_result());
          win_q.delete();
        end
      end
    end
    prev_rst = rst;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    din = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, input int mx, input int mn, input int i1,
                          input int i2, input bit d, input bit t, input bit imm);
    int n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    if (imm) chk({nm, "_latency"}, n, 0);
    chk({nm, "_max"}, max_o, mx);
    chk({nm, "_min"}, min_o, mn);
    chk({nm, "_idx1"}, max_idx1, i1);
    chk({nm, "_idx2"}, max_idx2, i2);
    chk({nm, "_dplx_o"}, dplx_o, d);
    chk({nm, "_tc_o"}, tc_o, t);
    chk({nm, "_hold_ready"}, in_ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // unsigned simplex, tie keeps first max
    tc = 0; dplx = 0; win_len = 4;
    send(8'h10); send(8'hF0); send(8'h7F); send(8'hF0);
    wait_res("t1", 'hF0, 'h10, 0, 1, 0, 0, 1);

    // signed simplex
    tc = 1;
    send(8'h10); send(8'hF0); send(8'h7F); send(8'hF0);
    wait_res("t2", 'h7F, 'hF0, 0, 2, 0, 1, 1);

    // signed duplex
    tc = 1; dplx = 1; win_len = 3;
    send(8'h7F); send(8'h81); send(8'h18);
    wait_res("t3", 'h71, 'h88, 1, 0, 1, 1, 1);

    // win_len 0 behaves as 1
    tc = 0; dplx = 0; win_len = 0;
    send(8'h5A);
    wait_res("t4", 'h5A, 'h5A, 0, 0, 0, 0, 1);

    // backpressure; win_len change mid-window is ignored
    out_ready = 0; tc = 0; dplx = 1; win_len = 2;
    send(8'h3C);
    win_len = 5;
    send(8'hA5);
    wait_res("t5", 'hAC, 'h35, 0, 1, 1, 0, 1);
    in_valid = 1; din = 8'h99;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_max", max_o, 'hAC);
      @(posedge clk); #1;
    end
    out_ready = 1; win_len = 2;
    send(8'h99); send(8'hAA);
    wait_res("t5b", 'hAA, 'h99, 1, 1, 1, 0, 1);

    // reset mid-window
    tc = 0; dplx = 0; win_len = 4;
    send(8'hEE); send(8'h00);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_max", max_o, 0);
    chk("t6_in_ready", in_ready, 1);
    @(posedge clk); #1;
    win_len = 2;
    send(8'h03); send(8'h01);
    wait_res("t6", 'h03, 'h01, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", errors);
    $fatal(1);
  end

endmodule
